// File: rtl/exc_pkg.sv
// Exception-tracking package: ExcCode constants, source-index -> ExcCode table,
// mask of sources that capture a faulting address, and the per-slot record.
package exc_pkg;

  localparam int unsigned MAX_SRC = 16;
  localparam int unsigned IDX_W   = 4;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CODE[j] is the ExcCode raised by source j (listed from index 15 down to 0)
  localparam logic [MAX_SRC-1:0][4:0] CODE = {
    EXC_RI,   EXC_RI,   EXC_RI,  EXC_RI,
    EXC_RI,   EXC_RI,   EXC_RI,  EXC_RI,
    EXC_ADES, EXC_ADEL, EXC_OV,  EXC_RI,
    EXC_BP,   EXC_SYS,  EXC_ADES, EXC_ADEL
  };

  // Sources 0,1,6,7 are address errors and capture the stage address
  localparam logic [MAX_SRC-1:0] ADDR_SRC = 16'h00C3;

  typedef struct packed {
    logic        vld;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badva;
    logic [31:0] pc;
  } slot_t;

endpackage

// File: rtl/exc_prio_enc.sv
// First-hit exception source encoder: the lowest-index active request wins.
// Ports: req (NSRC requests) -> hit, idx (winning index), code (ExcCode of winner).
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0]  req,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [4:0]       code
);

  // Scan high to low so the lowest active index is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int j = int'(NSRC) - 1; j >= 0; j--) begin
      if (req[j]) begin
        hit = 1'b1;
        idx = IDX_W'(j);
      end
    end
    code = hit ? CODE[idx] : 5'd0;
  end

endmodule

// File: rtl/exc_track_pipe.sv
// Exception tracking pipeline: one slot per stage follows each instruction,
// keeps its oldest exception and presents it at the last slot for commit.
// Ports: clk, reset (sync, active-high); src_i/addr_i per-stage sources and
// addresses; pc_i/ivld_i instruction entering slot 0; stall_i per-slot hold;
// flush_i clears all slots; eret_i loads a clean slot 0; kill_o per-slot
// pending exception; exc_vld_o/exc_code_o/badva_o/epc_o from the last slot;
// exc_cnt_o saturating committed-exception count.
// Optional: EXC_TRACK_INT_EN adds int_i, a level interrupt taken at the last slot.
module exc_track_pipe
  import exc_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NSRC   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSTAGE*NSRC-1:0] src_i,
  input  logic [NSTAGE*32-1:0]   addr_i,
  input  logic [31:0]            pc_i,
  input  logic                   ivld_i,
  input  logic [NSTAGE-1:0]      stall_i,
  input  logic                   flush_i,
  input  logic                   eret_i,
`ifdef EXC_TRACK_INT_EN
  input  logic                   int_i,
`endif
  output logic [NSTAGE-1:0]      kill_o,
  output logic                   exc_vld_o,
  output logic [4:0]             exc_code_o,
  output logic [31:0]            badva_o,
  output logic [31:0]            epc_o,
  output logic [15:0]            exc_cnt_o
);

  slot_t            q    [NSTAGE];
  slot_t            d    [NSTAGE];
  logic [NSTAGE-1:0] hit;
  logic [IDX_W-1:0]  idx  [NSTAGE];
  logic [4:0]        code [NSTAGE];
  logic [15:0]       cnt;

  // One encoder per stage
  for (genvar s = 0; s < NSTAGE; s++) begin : g_enc
    exc_prio_enc #(.NSRC(NSRC)) u_enc (
      .req  (src_i[s*NSRC +: NSRC]),
      .hit  (hit[s]),
      .idx  (idx[s]),
      .code (code[s])
    );
  end

  // Next-state per slot: flush > stall > eret (slot 0) > normal load
  always_comb begin
    d[0] = q[0];
    if (flush_i) begin
      d[0].vld = 1'b0;
      d[0].exc = 1'b0;
    end else if (!stall_i[0]) begin
      d[0].pc = pc_i;
      if (eret_i) begin
        d[0].vld  = 1'b1;
        d[0].exc  = 1'b0;
        d[0].code = 5'd0;
      end else begin
        d[0].vld  = ivld_i;
        d[0].exc  = hit[0];
        d[0].code = code[0];
        if (hit[0] && ADDR_SRC[idx[0]]) d[0].badva = addr_i[31:0];
      end
    end

    for (int s = 1; s < int'(NSTAGE); s++) begin
      d[s] = q[s];
      if (flush_i) begin
        d[s].vld = 1'b0;
        d[s].exc = 1'b0;
      end else if (stall_i[s]) begin
        d[s] = q[s];
      end else if (stall_i[s-1]) begin
        // Upstream held: insert a bubble
        d[s].vld = 1'b0;
        d[s].exc = 1'b0;
      end else begin
        d[s] = q[s-1];
        // An older exception rides through untouched
        if (!q[s-1].exc && q[s-1].vld && hit[s]) begin
          d[s].exc  = 1'b1;
          d[s].code = code[s];
          if (ADDR_SRC[idx[s]]) d[s].badva = addr_i[s*32 +: 32];
        end
`ifdef EXC_TRACK_INT_EN
        if (s == int'(NSTAGE) - 1 && int_i && q[s-1].vld && !q[s-1].exc) begin
          d[s].exc   = 1'b1;
          d[s].code  = EXC_INT;
          d[s].badva = q[s-1].badva;
        end
`endif
      end
    end
  end

  // Slot registers and saturating commit counter (a commit on a flush edge still counts)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(NSTAGE); s++) q[s] <= '0;
      cnt <= '0;
    end else begin
      for (int s = 0; s < int'(NSTAGE); s++) q[s] <= d[s];
      if (q[NSTAGE-1].exc && !stall_i[NSTAGE-1] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    kill_o = '0;
    for (int s = 0; s < int'(NSTAGE); s++) kill_o[s] = q[s].exc;
  end

  assign exc_vld_o  = q[NSTAGE-1].exc;
  assign exc_code_o = q[NSTAGE-1].code;
  assign badva_o    = q[NSTAGE-1].badva;
  assign epc_o      = q[NSTAGE-1].pc;
  assign exc_cnt_o  = cnt;

endmodule

// File: tb/tb_exc_track_pipe.sv
// Self-checking bench for exc_track_pipe (NSTAGE=3, NSRC=8): directed
// scenarios plus a pipelined random stream checked through a commit scoreboard.
// Define EXC_TRACK_INT_EN to also exercise the interrupt port.
module tb_exc_track_pipe;

  localparam int unsigned NS   = 3;
  localparam int unsigned NR   = 8;
  localparam int unsigned NRND = 200;
  localparam int unsigned NT   = NRND + NS;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS*NR-1:0] src_i;
  logic [NS*32-1:0] addr_i;
  logic [31:0]      pc_i;
  logic             ivld_i;
  logic [NS-1:0]    stall_i;
  logic             flush_i;
  logic             eret_i;
`ifdef EXC_TRACK_INT_EN
  logic             int_i;
`endif
  logic [NS-1:0]    kill_o;
  logic             exc_vld_o;
  logic [4:0]       exc_code_o;
  logic [31:0]      badva_o;
  logic [31:0]      epc_o;
  logic [15:0]      exc_cnt_o;

  exc_track_pipe #(.NSTAGE(NS), .NSRC(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_i      (src_i),
    .addr_i     (addr_i),
    .pc_i       (pc_i),
    .ivld_i     (ivld_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .eret_i     (eret_i),
`ifdef EXC_TRACK_INT_EN
    .int_i      (int_i),
`endif
    .kill_o     (kill_o),
    .exc_vld_o  (exc_vld_o),
    .exc_code_o (exc_code_o),
    .badva_o    (badva_o),
    .epc_o      (epc_o),
    .exc_cnt_o  (exc_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] badva;
    logic        chk_ba;
  } exp_t;

  exp_t  exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;
  int    exp_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference source table, independent of the design package
  function automatic logic [4:0] ref_code(input int j);
    case (j)
      0: ref_code = 5'd4;  1: ref_code = 5'd5;  2: ref_code = 5'd8;  3: ref_code = 5'd9;
      4: ref_code = 5'd10; 5: ref_code = 5'd12; 6: ref_code = 5'd4;  7: ref_code = 5'd5;
      default: ref_code = 5'd10;
    endcase
  endfunction

  function automatic logic ref_addr(input int j);
    ref_addr = (j == 0 || j == 1 || j == 6 || j == 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: instruction valid/pc, a single stage's source/address, then clock
  task automatic cyc(input logic v, input logic [31:0] pc, input int st,
                     input logic [NR-1:0] s, input logic [31:0] a);
    ivld_i = v;
    pc_i   = pc;
    src_i  = '0;
    addr_i = '0;
    src_i[st*NR +: NR]  = s;
    addr_i[st*32 +: 32] = a;
    tick();
  endtask

  // Commit monitor: pop the scoreboard on each committing cycle
  always @(negedge clk) begin
    if (mon_en && !reset && exc_vld_o && !stall_i[NS-1]) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_commit", 32'(exc_code_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rnd_code", 32'(exc_code_o), 32'(e.code));
        check_eq("rnd_epc", epc_o, e.pc);
        if (e.chk_ba) check_eq("rnd_badva", badva_o, e.badva);
      end
    end
  end

  logic            r_vld  [NT];
  logic [31:0]     r_pc   [NT];
  logic [NR-1:0]   r_src  [NT][NS];
  logic [31:0]     r_addr [NT][NS];

  initial begin
    reset = 1'b1; src_i = '0; addr_i = '0; pc_i = '0; ivld_i = 1'b0;
    stall_i = '0; flush_i = 1'b0; eret_i = 1'b0;
`ifdef EXC_TRACK_INT_EN
    int_i = 1'b0;
`endif
    tick(); tick();
    check_eq("rst_kill", 32'(kill_o), 32'd0);
    check_eq("rst_vld", 32'(exc_vld_o), 32'd0);
    check_eq("rst_code", 32'(exc_code_o), 32'd0);
    check_eq("rst_badva", badva_o, 32'd0);
    check_eq("rst_epc", epc_o, 32'd0);
    check_eq("rst_cnt", 32'(exc_cnt_o), 32'd0);
    reset = 1'b0;

    // AdEL at stage 0 reaches the last slot after 3 edges
    cyc(1'b1, 32'h0000_0400, 0, 8'h01, 32'h1002);
    check_eq("adel_kill1", 32'(kill_o), 32'b001);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("adel_lat2", 32'(exc_vld_o), 32'd0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("adel_vld", 32'(exc_vld_o), 32'd1);
    check_eq("adel_code", 32'(exc_code_o), 32'd4);
    check_eq("adel_badva", badva_o, 32'h1002);
    check_eq("adel_epc", epc_o, 32'h400);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    exp_cnt++;
    check_eq("adel_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

    // RI at stage 1 is older than Ov at stage 2
    cyc(1'b1, 32'h0000_0800, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 1, 8'h10, 32'h0);
    cyc(1'b0, 32'h0, 2, 8'h20, 32'h0);
    check_eq("oldest_code", 32'(exc_code_o), 32'd10);
    check_eq("oldest_epc", epc_o, 32'h800);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    exp_cnt++;
    check_eq("oldest_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

    // Stall slots 0,1 for two cycles with an exception held in slot 1
    cyc(1'b1, 32'h0000_0C00, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 1, 8'h10, 32'h0);
    check_eq("stall_pre_kill", 32'(kill_o), 32'b010);
    stall_i = 3'b011;
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("stall1_kill", 32'(kill_o), 32'b010);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("stall2_kill", 32'(kill_o), 32'b010);
    check_eq("stall2_vld", 32'(exc_vld_o), 32'd0);
    stall_i = 3'b000;
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("stall_rel_vld", 32'(exc_vld_o), 32'd1);
    check_eq("stall_rel_epc", epc_o, 32'hC00);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    exp_cnt++;
    check_eq("stall_once_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

    // Flush while kill_o=110: commit of slot 2 still counts
    cyc(1'b1, 32'h0000_1000, 0, 8'h04, 32'h0);
    cyc(1'b1, 32'h0000_1004, 0, 8'h08, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("flush_pre_kill", 32'(kill_o), 32'b110);
    flush_i = 1'b1;
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    flush_i = 1'b0;
    exp_cnt++;
    check_eq("flush_kill", 32'(kill_o), 32'd0);
    check_eq("flush_vld", 32'(exc_vld_o), 32'd0);
    check_eq("flush_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

    // eret ignores slot-0 sources
    eret_i = 1'b1;
    cyc(1'b1, 32'h0000_2000, 0, 8'h01, 32'h55);
    eret_i = 1'b0;
    check_eq("eret_kill", 32'(kill_o), 32'd0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    check_eq("eret_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

`ifdef EXC_TRACK_INT_EN
    // Interrupt taken by a clean instruction; an in-flight Sys wins instead
    cyc(1'b1, 32'h0000_3000, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    int_i = 1'b1;
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    int_i = 1'b0;
    check_eq("int_vld", 32'(exc_vld_o), 32'd1);
    check_eq("int_code", 32'(exc_code_o), 32'd0);
    check_eq("int_epc", epc_o, 32'h3000);
    cyc(1'b1, 32'h0000_3004, 0, 8'h04, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    int_i = 1'b1;
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    int_i = 1'b0;
    check_eq("int_sys_code", 32'(exc_code_o), 32'd8);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    exp_cnt += 2;
    check_eq("int_cnt", 32'(exc_cnt_o), 32'(exp_cnt));
`endif

    // Pipelined random stream; garbage on stages behind an empty slot
    for (int t = 0; t < int'(NT); t++) begin
      r_vld[t] = (t < int'(NRND)) && ($urandom_range(0, 3) != 0);
      r_pc[t]  = $urandom;
      for (int s = 0; s < int'(NS); s++) begin
        r_src[t][s]  = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
        r_addr[t][s] = $urandom;
      end
    end
    mon_en = 1'b1;
    for (int t = 0; t < int'(NT); t++) begin
      ivld_i = r_vld[t];
      pc_i   = r_pc[t];
      src_i[0 +: NR]  = r_vld[t] ? r_src[t][0] : '0;
      addr_i[0 +: 32] = r_addr[t][0];
      for (int s = 1; s < int'(NS); s++) begin
        if (t >= s && r_vld[t-s]) begin
          src_i[s*NR +: NR]  = r_src[t-s][s];
          addr_i[s*32 +: 32] = r_addr[t-s][s];
        end else begin
          src_i[s*NR +: NR]  = NR'($urandom);
          addr_i[s*32 +: 32] = $urandom;
        end
      end
      if (r_vld[t]) begin
        exp_t e;
        logic found;
        found = 1'b0;
        e.code = '0; e.pc = r_pc[t]; e.badva = '0; e.chk_ba = 1'b0;
        for (int s = 0; s < int'(NS); s++) begin
          for (int j = 0; j < int'(NR); j++) begin
            if (!found && r_src[t][s][j]) begin
              found    = 1'b1;
              e.code   = ref_code(j);
              e.chk_ba = ref_addr(j);
              e.badva  = r_addr[t][s];
            end
          end
        end
        if (found) begin
          exp_q.push_back(e);
          exp_cnt++;
        end
      end
      tick();
    end
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    cyc(1'b0, 32'h0, 0, 8'h00, 32'h0);
    mon_en = 1'b0;
    check_eq("rnd_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rnd_cnt", 32'(exc_cnt_o), 32'(exp_cnt));

    // Saturation: more than 0x10000 back-to-back commits
    ivld_i = 1'b1; src_i = '0; addr_i = '0;
    src_i[0] = 1'b1;
    for (int i = 0; i < 65536 + 8; i++) tick();
    check_eq("sat_cnt", 32'(exc_cnt_o), 32'hFFFF);
    tick();
    check_eq("sat_hold", 32'(exc_cnt_o), 32'hFFFF);

    // Reset beats stall and flush
    stall_i = '1; flush_i = 1'b1; reset = 1'b1;
    tick();
    check_eq("rst2_kill", 32'(kill_o), 32'd0);
    check_eq("rst2_vld", 32'(exc_vld_o), 32'd0);
    check_eq("rst2_cnt", 32'(exc_cnt_o), 32'd0);
    check_eq("rst2_epc", epc_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
